// File: rtl/relu_ctrl_pkg.sv
// Shared types for the ReLU post-processing stage controller: FSM state
// encoding and the path-select mode constants.
package relu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_1X7 = 1'b0;  // pass-through path, ReLU S2 = 1
  localparam logic MODE_1X1 = 1'b1;  // sum + sum1 path, ReLU S2 = 0

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/relu_out_fifo.sv
// Two-entry synchronous FIFO holding {data, idx} results on their way to the
// output stream. Push and pop may coincide at any fill level.
module relu_out_fifo #(
  parameter int DW = 44
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // NOTE: storage is deliberately not reset; the head is masked to zero while
  // empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid = (cnt != 2'd0);
  assign count = cnt;
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/relu_stage_ctrl.sv
// Frame sequencer for the ReLU stage: picks the 1x7 or 1x1 path, aligns
// valid with the ReLU latency and streams tagged results through a 2-entry FIFO.
module relu_stage_ctrl
  import relu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             relu_s2,
  input  logic [WIDTH-1:0] relu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LEN_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int FW = WIDTH + LEN_W;

  state_t           state;
  state_t           state_nx;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt;
  logic [LEN_W-1:0] wr_idx;
  logic             inflight;
  logic             fire;
  logic             push;
  logic             pop;
  logic [1:0]       fifo_cnt;
  logic [1:0]       used;
  logic [FW-1:0]    head;
  logic             fifo_valid;

  // A beat is accepted only if a FIFO slot is guaranteed for it, counting the
  // result still inside the registered ReLU.
  assign used     = fifo_cnt + {1'b0, inflight};
  assign in_ready = (state == ST_RUN) && (used < 2'd2) && (in_cnt < len_q);
  assign fire     = in_valid && in_ready;
  assign push     = (fire && (mode_q == MODE_1X7)) || inflight;
  assign pop      = out_valid && out_ready;

  // NOTE: every output of this block gets a default first, so no path can
  // leave state_nx unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (fire && (in_cnt == len_q - 1'b1)) state_nx = ST_DRAIN;
      // Leave as the last entry pops so done follows the final pop directly.
      ST_DRAIN: if (!inflight && ((fifo_cnt == 2'd0) || (fifo_cnt == 2'd1 && pop)))
                  state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_1X7;
      len_q    <= '0;
      in_cnt   <= '0;
      wr_idx   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= fire && (mode_q == MODE_1X1);
      if (state == ST_IDLE && start) begin
        mode_q <= cfg_mode;
        len_q  <= cfg_len;
        in_cnt <= '0;
        wr_idx <= '0;
      end else begin
        if (fire) in_cnt <= in_cnt + 1'b1;
        if (push) wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  relu_out_fifo #(.DW(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({relu_out, wr_idx}),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .count     (fifo_cnt)
  );

  assign out_valid = fifo_valid;
  assign out_data  = head[FW-1:LEN_W];
  assign out_idx   = head[LEN_W-1:0];
  assign out_last  = out_valid && (out_idx == len_q - 1'b1);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign relu_s2   = (state == ST_IDLE) ? 1'b1 : ~mode_q;

endmodule

// File: tb/tb_relu_stage_ctrl.sv
// Bench for relu_stage_ctrl: a behavioural ReLU model feeds relu_out, and a
// scoreboard of accepted beats predicts the output stream.
module tb_relu_stage_ctrl;
  import relu_ctrl_pkg::*;

  localparam int WIDTH = 32;
  localparam int LEN_W = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start, cfg_mode, in_valid, in_ready, relu_s2;
  logic [LEN_W-1:0]        cfg_len;
  logic signed [WIDTH-1:0] sum, sum1, relu_out, relu_q;
  logic                    out_valid, out_ready, out_last, busy, done;
  logic [WIDTH-1:0]        out_data;
  logic [LEN_W-1:0]        out_idx;

  always #5 clk = ~clk;

  relu_stage_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .relu_s2(relu_s2), .relu_out(relu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // ReLU block: combinational on S2=1, registered sum+sum1 on S2=0.
  function automatic logic signed [WIDTH-1:0] hw_relu(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? '0 : x;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) relu_q <= '0;
    else     relu_q <= hw_relu(sum + sum1);
  assign relu_out = relu_s2 ? hw_relu(sum) : relu_q;

  function automatic int model(input int s, input int s1, input int m);
    int v;
    v = (m != 0) ? s + s1 : s;
    return (v < 0) ? 0 : v;
  endfunction

  typedef struct {
    int mode;
    int s;
    int s1;
    int exp;
  } vec_t;
  vec_t vec [7];

  int checks = 0, errors = 0;
  int cyc = 0, fcyc = 0, rdy_mode = 0;
  int model_mode = 0, model_len = 0, acc = 0;
  int exp_val[$], exp_idx[$], fire_cyc[$], got[$];
  int stim_s[$], stim_s1[$];
  int done_cnt = 0, busy_cnt = 0, s2_bad = 0, stall = 0;
  int last_pop_cyc = 0, done_cyc = 0;
  bit chk_lat = 0, head_seen = 0;
  bit prev_v = 0, prev_r = 0;
  logic [WIDTH-1:0] prev_d;
  logic [LEN_W-1:0] prev_i;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    fcyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = !(fcyc >= 2 && fcyc <= 6);
    endcase
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0;
      head_seen = 0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
        check("hold_idx", out_idx, prev_i);
      end
      if (!busy) check("in_ready_idle", in_ready, 0);
      if (busy && in_valid && !in_ready) stall++;
      if (in_valid && in_ready) begin
        check("credit", exp_val.size() < 2, 1);
        exp_val.push_back(model(int'(sum), int'(sum1), model_mode));
        exp_idx.push_back(acc);
        fire_cyc.push_back(cyc);
        acc++;
      end
      if (out_valid) begin
        if (exp_val.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          check("data", out_data, exp_val[0]);
          check("idx", out_idx, exp_idx[0]);
          check("last", out_last, exp_idx[0] == model_len - 1);
          if (chk_lat && !head_seen) check("latency", cyc - fire_cyc[0], 1 + model_mode);
          head_seen = 1;
          if (out_ready) begin
            got.push_back(int'(out_data));
            void'(exp_val.pop_front());
            void'(exp_idx.pop_front());
            void'(fire_cyc.pop_front());
            head_seen = 0;
            last_pop_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (relu_s2 !== (busy ? (model_mode == 0) : 1'b1)) s2_bad++;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_i = out_idx;
    end
  end

  task automatic start_frame(input int m, input int len);
    cfg_mode = 1'(m);
    cfg_len = LEN_W'(len);
    model_mode = m;
    model_len = len;
    acc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    got.delete();
    start = 1'b1;
    fcyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_beats(input int n, input bit restart);
    int i = 0;
    int tmo = 0;
    bit pulsed = 0;
    bit a;
    while (i < n && tmo < n * 8 + 100) begin
      in_valid = 1'b1;
      sum = stim_s[i];
      sum1 = stim_s1[i];
      start = 1'b0;
      if (restart && i == 2 && !pulsed) begin
        start = 1'b1;
        cfg_mode = ~cfg_mode;
        cfg_len = LEN_W'(9);
        pulsed = 1;
      end
      @(negedge clk);
      a = in_ready;
      @(posedge clk); #1;
      if (a) i++;
      tmo++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("beats_sent", i, n);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_after", busy, 0);
    check("done_once", done_cnt, 1);
    check("out_count", got.size(), model_len);
    check("queue_empty", exp_val.size(), 0);
    check("relu_s2", s2_bad, 0);
  endtask

  task automatic run_frame(input int m, input int len, input bit restart);
    start_frame(m, len);
    if (len > 0) send_beats(len, restart);
    wait_done(len * 8 + 100);
  endtask

  task automatic rand_stim(input int len);
    stim_s.delete();
    stim_s1.delete();
    for (int i = 0; i < len; i++) begin
      stim_s.push_back(int'($urandom_range(0, 200)) - 100);
      stim_s1.push_back(int'($urandom_range(0, 200)) - 100);
    end
  endtask

  initial begin
    vec[0] = '{0, 5, 0, 5};
    vec[1] = '{0, -3, 0, 0};
    vec[2] = '{0, 0, 0, 0};
    vec[3] = '{0, 7, 0, 7};
    vec[4] = '{1, 2, 3, 5};
    vec[5] = '{1, -8, 1, 0};
    vec[6] = '{1, 4, -4, 0};

    rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
    in_valid = 1'b0; sum = '0; sum1 = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_relu_s2", relu_s2, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1x7 frame then 1x1 frame, both from the vector table.
    chk_lat = 1;
    for (int t = 0; t < 2; t++) begin
      int base = (t == 0) ? 0 : 4;
      int len = (t == 0) ? 4 : 3;
      stim_s.delete();
      stim_s1.delete();
      for (int i = 0; i < len; i++) begin
        stim_s.push_back(vec[base + i].s);
        stim_s1.push_back(vec[base + i].s1);
      end
      run_frame(vec[base].mode, len, 0);
      for (int i = 0; i < len && i < got.size(); i++)
        check($sformatf("table_out%0d", base + i), got[i], vec[base + i].exp);
      check("done_after_pop", done_cyc - last_pop_cyc, 1);
    end
    chk_lat = 0;

    // Backpressure: out_ready low on frame cycles 2..6.
    rdy_mode = 2;
    stall = 0;
    rand_stim(6);
    run_frame(1, 6, 0);
    check("stalled", stall > 0, 1);
    rdy_mode = 0;

    // Zero-length frame.
    start_frame(0, 0);
    wait_done(20);
    check("len0_busy", busy_cnt >= 1 && busy_cnt <= 2, 1);

    // Start re-pulsed mid-frame with different cfg must be ignored.
    rand_stim(4);
    run_frame(1, 4, 1);

    // Reset in the middle of a 1x1 frame after two beats.
    rand_stim(5);
    start_frame(1, 5);
    send_beats(2, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_relu_s2", relu_s2, 1);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_out_last", out_last, 0);
    exp_val.delete(); exp_idx.delete(); fire_cyc.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("mid_rst_no_done", done_cnt, 0);
    rand_stim(5);
    run_frame(1, 5, 0);

    // Randomized frames with random downstream backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      int m = int'($urandom_range(0, 1));
      int l = int'($urandom_range(1, 9));
      rand_stim(l);
      run_frame(m, l, 0);
    end
    rdy_mode = 0;

    // Longest supported frame: index counters must reach len-1 without wrap.
    rand_stim(4095);
    run_frame(0, 4095, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
